// File: rtl/dmem_mmio_responder.sv
// Memory-stage data responder: word RAM plus a small MMIO window
// (SEG, LED, SW, CYCLE, ERR) and the 8-digit seven-segment scanner.
module dmem_mmio_responder #(
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'h1002_0000,
  parameter int          SCAN_DIV   = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        dm_r,
  input  logic        dm_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cath,
  output logic        bus_err
);

  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [31:0] RAM_BYTES  = 32'(DEPTH * 4);
  localparam logic [31:0] MMIO_BYTES = 32'h14;

  localparam logic [2:0] REG_SEG = 3'd0;
  localparam logic [2:0] REG_LED = 3'd1;
  localparam logic [2:0] REG_SW  = 3'd2;
  localparam logic [2:0] REG_CYC = 3'd3;
  localparam logic [2:0] REG_ERR = 3'd4;

  // Unsigned offsets wrap below the base, so one compare covers both bounds.
  logic [31:0] ram_off, mmio_off;
  logic        ram_hit, mmio_hit, misal, acc_ok, rd_en, wr_en, acc_err;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [2:0]  reg_sel;

  assign ram_off  = addr - DMEM_BASE;
  assign mmio_off = addr - MMIO_BASE;
  assign ram_hit  = ram_off < RAM_BYTES;
  assign mmio_hit = ~ram_hit & (mmio_off < MMIO_BYTES);
  assign misal    = |addr[1:0];
  assign acc_ok   = (ram_hit | mmio_hit) & ~misal;
  assign rd_en    = cs & dm_r & acc_ok;
  assign wr_en    = cs & dm_w & acc_ok;
  assign acc_err  = cs & (dm_r | dm_w) & ~acc_ok;
  assign ram_idx  = ram_off[DEPTH_LOG2+1:2];
  assign reg_sel  = mmio_off[4:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_off[31:DEPTH_LOG2+2], ram_off[1:0],
                              mmio_off[31:5], mmio_off[1:0]};

  logic reg_wr_seg, reg_wr_led, reg_wr_cyc, reg_wr_err;
  assign reg_wr_seg = wr_en & mmio_hit & (reg_sel == REG_SEG);
  assign reg_wr_led = wr_en & mmio_hit & (reg_sel == REG_LED);
  assign reg_wr_cyc = wr_en & mmio_hit & (reg_sel == REG_CYC);
  assign reg_wr_err = wr_en & mmio_hit & (reg_sel == REG_ERR);

  // RAM is never reset; a store landing while reset is held is dropped.
  logic [31:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_en && ram_hit && rst) mem_q[ram_idx] <= wdata;
  end

  logic [31:0]         seg_q, seg_d, cyc_q, cyc_d;
  logic [15:0]         led_q, led_d, sw_meta_q, sw_sync_q;
  logic                err_q, err_d;
  logic [SCAN_DIV-1:0] pre_q, pre_d;
  logic [2:0]          dig_q, dig_d;

  always_comb begin
    seg_d = reg_wr_seg ? wdata : seg_q;
    led_d = reg_wr_led ? wdata[15:0] : led_q;
    cyc_d = reg_wr_cyc ? 32'h0 : cyc_q + 32'd1;
    err_d = acc_err ? 1'b1 : (reg_wr_err ? 1'b0 : err_q);
    pre_d = pre_q + 1'b1;
    dig_d = (&pre_q) ? dig_q + 3'd1 : dig_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q     <= '0;
      led_q     <= '0;
      cyc_q     <= '0;
      err_q     <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      pre_q     <= '0;
      dig_q     <= '0;
    end else begin
      seg_q     <= seg_d;
      led_q     <= led_d;
      cyc_q     <= cyc_d;
      err_q     <= err_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      pre_q     <= pre_d;
      dig_q     <= dig_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rd_en) begin
      if (ram_hit) rdata = mem_q[ram_idx];
      else begin
        case (reg_sel)
          REG_SEG: rdata = seg_q;
          REG_LED: rdata = {16'h0, led_q};
          REG_SW:  rdata = {16'h0, sw_sync_q};
          REG_CYC: rdata = cyc_q;
          REG_ERR: rdata = {31'h0, err_q};
          default: rdata = 32'h0;
        endcase
      end
    end
  end

  logic [3:0] nib;
  assign nib = seg_q[{dig_q, 2'b00} +: 4];

  always_comb begin
    case (nib)
      4'h0: seg_cath = 8'hC0;
      4'h1: seg_cath = 8'hF9;
      4'h2: seg_cath = 8'hA4;
      4'h3: seg_cath = 8'hB0;
      4'h4: seg_cath = 8'h99;
      4'h5: seg_cath = 8'h92;
      4'h6: seg_cath = 8'h82;
      4'h7: seg_cath = 8'hF8;
      4'h8: seg_cath = 8'h80;
      4'h9: seg_cath = 8'h90;
      4'hA: seg_cath = 8'h88;
      4'hB: seg_cath = 8'h83;
      4'hC: seg_cath = 8'hC6;
      4'hD: seg_cath = 8'hA1;
      4'hE: seg_cath = 8'h86;
      default: seg_cath = 8'h8E;
    endcase
  end

  assign seg_an  = ~(8'b1 << dig_q);
  assign led     = led_q;
  assign bus_err = err_q;

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder for the pipeline's memory-stage data port. Serves load/store requests from the CPU's ex-me stage registers.
- Backs the port with a word-addressed data RAM plus a small memory-mapped I/O window: seven-segment display, LEDs, switches, cycle counter and error register.
- Read data is combinational, so the CPU latches it into its me-wb register on the same edge.
- The block also drives the multiplexed 8-digit seven-segment display from the SEG register.

Parameters:
- DMEM_BASE, 32'h10010000, byte address of RAM word 0.
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words).
- MMIO_BASE, 32'h10020000, byte address of the first MMIO register.
- SCAN_DIV, 17, prescaler width; the display digit advances every 2^SCAN_DIV clocks.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  chip select from memory stage.
- dm_r  in  1  read request.
- dm_w  in  1  write request, qualified by cs.
- addr  in  32  byte address (CPU ALU result).
- wdata  in  32  store data (CPU rt value).
- rdata  out  32  load data, combinational.
- sw  in  16  board switches, asynchronous to clk.
- led  out  16  LED register.
- seg_an  out  8  digit enables, active-low, bit k = digit k.
- seg_cath  out  8  segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}.
- bus_err  out  1  sticky access-error flag.

Behaviour:
- Decode:
  - RAM hit: addr in [DMEM_BASE, DMEM_BASE + 4*2^DEPTH_LOG2). Word index = (addr-DMEM_BASE)[DEPTH_LOG2+1:2].
  - MMIO hit: addr in [MMIO_BASE, MMIO_BASE+0x14).
  - Anything else is unmapped.
  - Misaligned: addr[1:0] != 0.
- MMIO map (offset from MMIO_BASE):
  - 0x00 SEG: read/write, 32 bits.
  - 0x04 LED: read/write, bits [15:0]; write ignores [31:16]; read returns zero in [31:16].
  - 0x08 SW: read-only, {16'b0, sw_sync}.
  - 0x0C CYCLE: read-only counter; any write clears it.
  - 0x10 ERR: read {31'b0, bus_err}; any write clears bus_err.
- Read path:
  - rdata = selected word when cs & dm_r & valid access, else 32'h0. Purely combinational, no cycle latency.
  - Same-cycle read and write to the same address returns the pre-write value; the new value is visible from the next cycle.
- Write: takes effect on the rising edge when cs & dm_w & valid access. RAM is written as a full word; no byte enables.
- Errors:
  - Condition: cs & (dm_r | dm_w) & (misaligned | unmapped).
  - Effect: the write is dropped, rdata = 0, and bus_err is set at the next edge.
  - bus_err stays set until an ERR write or reset. If an error and an ERR write occur in the same cycle, the set wins.
- cs=0: no state change from the port and rdata=0, regardless of dm_r/dm_w.
- CYCLE:
  - Increments by 1 every clock and wraps 32'hFFFFFFFF -> 0.
  - A write in cycle N makes the value 0 after edge N; counting resumes from 0, so it reads 1 in cycle N+2. Clear wins over increment.
- SW synchroniser: two flops, reset 0. A switch change is visible in SW reads 2 clocks after it is sampled.
- Display scanner:
  - A SCAN_DIV-bit prescaler counts every clock.
  - When the prescaler equals all-ones, digit index d (3 bits) increments, wrapping 7 -> 0.
  - seg_an = ~(8'b1 << d).
  - seg_cath = hex font of SEG[4d+3:4d], with dp off.
  - Font: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
  - A SEG write is reflected on the currently active digit from the next cycle; the scan is not restarted.
- Reset (rst low, asynchronous, any time including mid-access):
  - SEG=0, LED=0, CYCLE=0, bus_err=0, sw_sync=0, prescaler=0, d=0.
  - Outputs: led=16'h0, seg_an=8'hFE, seg_cath=8'hC0.
  - rdata follows the combinational rules with the reset register values.
  - RAM contents are not reset and are preserved across reset.
  - A write coinciding with reset assertion is not performed.

Test Plan:
- Write 32'hDEADBEEF to 0x10010004, then read 0x10010004 next cycle -> rdata=32'hDEADBEEF; read 0x10010008 returns whatever was last written there.
- Same cycle: write 32'h1 and read at 0x10010010 (previously 32'h5) -> rdata=32'h5 that cycle, 32'h1 the next cycle.
- Write 0x10010002 (misaligned) and read 0x00000000 (unmapped) -> no RAM change, rdata=0, bus_err=1 next cycle; write 0x10020010 -> bus_err=0.
- Write SEG=32'h12345678 with SCAN_DIV=2 -> digit 0: an=FE, cath=80 ('8'); 4 clocks later digit 1: an=FD, cath=F8 ('7'); after digit 7 (cath=F9, '1') it wraps to digit 0.
- Write CYCLE at cycle N -> reads 1 at N+2; preload via force 32'hFFFFFFFF -> next read 0. sw=16'hA5A5 -> SW read 32'h0000A5A5 after 2 clocks.
- Assert rst low mid-store with LED=16'hFFFF -> led=0 immediately, seg_an=FE, seg_cath=C0; RAM word written before reset still reads back after release.
